// File: rtl/mm1_mem_ctrl_pkg.sv
// Shared constants and types for the layer-1 activation memory controller.
//   MM1_DEPTH     : entries in the layer-1 activation memory
//   MM_ADDR_W     : client-side address width
//   MM_DATA_W     : signed activation width
//   MM_MEM_ADDR_W : memory-side address width (client address zero-extended)
package mm_pkg;

  localparam int MM1_DEPTH     = 64;
  localparam int MM_ADDR_W     = 6;
  localparam int MM_DATA_W     = 32;
  localparam int MM_MEM_ADDR_W = 16;

  // Read clients sharing the single registered read port.
  typedef enum logic {
    CLIENT_A = 1'b0,  // layer-2 MAC
    CLIENT_B = 1'b1   // debug / readout
  } mm_client_e;

endpackage

// File: rtl/mm1_mem_ctrl_if.sv
// Bus interface between the producer, the two read consumers, the memory
// macro and the controller.
//   slave  : controller view (takes requests and memory read data, drives
//            grants, read valids, read data and memory-side controls)
//   master : environment view (producer, consumers and memory)
interface mm1_mem_ctrl_if
  import mm_pkg::*;
#(
  parameter int ADDR_W = MM_ADDR_W,
  parameter int DATA_W = MM_DATA_W
) ();

  logic                     wr_req;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     wr_gnt;

  logic                     rd_req_a;
  logic [ADDR_W-1:0]        rd_addr_a;
  logic                     rd_gnt_a;
  logic                     rd_valid_a;

  logic                     rd_req_b;
  logic [ADDR_W-1:0]        rd_addr_b;
  logic                     rd_gnt_b;
  logic                     rd_valid_b;

  logic signed [DATA_W-1:0] rd_data;

  logic [MM_MEM_ADDR_W-1:0] mem_write_addr;
  logic signed [DATA_W-1:0] mem_data_in;
  logic                     mem_write_enable;
  logic [MM_MEM_ADDR_W-1:0] mem_read_addr;
  logic signed [DATA_W-1:0] mem_data_out;

  modport slave (
    input  wr_req, wr_addr, wr_data,
    input  rd_req_a, rd_addr_a, rd_req_b, rd_addr_b,
    input  mem_data_out,
    output wr_gnt, rd_gnt_a, rd_gnt_b, rd_valid_a, rd_valid_b, rd_data,
    output mem_write_addr, mem_data_in, mem_write_enable, mem_read_addr
  );

  modport master (
    output wr_req, wr_addr, wr_data,
    output rd_req_a, rd_addr_a, rd_req_b, rd_addr_b,
    output mem_data_out,
    input  wr_gnt, rd_gnt_a, rd_gnt_b, rd_valid_a, rd_valid_b, rd_data,
    input  mem_write_addr, mem_data_in, mem_write_enable, mem_read_addr
  );

endinterface

// File: rtl/mm1_mem_ctrl_rr_arb2.sv
// Two-way round-robin arbiter for the shared read port.
//   clk, reset : clock, asynchronous active-high reset
//   eligible   : [0] client A eligible, [1] client B eligible
//   gnt        : one-hot (or zero) grant, combinational
// The priority pointer moves to the other client after every grant, so a
// lone eligible client is always served and contention alternates.
module rr_arb2
  import mm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] eligible,
  output logic [1:0] gnt
);

  mm_client_e prio_q, prio_d;

  always_comb begin
    gnt    = '0;
    prio_d = prio_q;
    case (eligible)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio_q == CLIENT_A) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
    if (gnt[0]) begin
      prio_d = CLIENT_B;
    end else if (gnt[1]) begin
      prio_d = CLIENT_A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= CLIENT_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mm1_mem_ctrl.sv
// Access controller for the 64-entry layer-1 activation memory.
//   clk, reset    : clock, asynchronous active-high reset
//   clear         : synchronous invalidate of all entries (new inference)
//   bus           : producer write port, consumer A/B read ports and the
//                   memory-side write/read controls (slave modport)
//   written_count : number of distinct entries written since clear/reset
//   layer_done    : every entry written
// Writes pass straight through; reads of unwritten entries, or of the entry
// being written in the same cycle, are held off until safe.
module mm1_mem_ctrl
  import mm_pkg::*;
#(
  parameter  int DEPTH = MM1_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  mm1_mem_ctrl_if.slave    bus,
  output logic [CNT_W-1:0] written_count,
  output logic             layer_done
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]     valid_q, valid_d, valid_base;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 layer_done_q;
  logic                 rd_valid_a_q, rd_valid_b_q;
  logic [MM_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]           elig, gnt;

  // Write side: never stalled.
  assign bus.wr_gnt           = bus.wr_req;
  assign bus.mem_write_enable = bus.wr_req;
  assign bus.mem_data_in      = bus.wr_data;
  assign bus.mem_write_addr   = {{(MM_MEM_ADDR_W - MM_ADDR_W){1'b0}}, bus.wr_addr};

  // A read colliding with a same-cycle write to the same entry is deferred
  // one cycle so the memory never sees both on one address.
  always_comb begin
    elig[0] = bus.rd_req_a && valid_q[bus.rd_addr_a]
              && !(bus.wr_req && (bus.wr_addr == bus.rd_addr_a));
    elig[1] = bus.rd_req_b && valid_q[bus.rd_addr_b]
              && !(bus.wr_req && (bus.wr_addr == bus.rd_addr_b));
  end

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .eligible (elig),
    .gnt      (gnt)
  );

  assign bus.rd_gnt_a = gnt[0];
  assign bus.rd_gnt_b = gnt[1];

  // Read address follows the granted client, otherwise holds the last one.
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (gnt[0]) begin
      rd_addr_d = bus.rd_addr_a;
    end else if (gnt[1]) begin
      rd_addr_d = bus.rd_addr_b;
    end
  end

  assign bus.mem_read_addr = {{(MM_MEM_ADDR_W - MM_ADDR_W){1'b0}}, rd_addr_d};
  assign bus.rd_data       = bus.mem_data_out;

  // Clear is applied before the write, so a write in the clear cycle survives
  // and counts as a fresh entry.
  always_comb begin
    valid_base = clear ? '0 : valid_q;
    count_d    = clear ? '0 : count_q;
    valid_d    = valid_base;
    if (bus.wr_req) begin
      valid_d[bus.wr_addr] = 1'b1;
      if (!valid_base[bus.wr_addr]) begin
        count_d = count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      count_q      <= '0;
      layer_done_q <= 1'b0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      count_q      <= count_d;
      layer_done_q <= (count_d == FULL_CNT);
      rd_valid_a_q <= gnt[0];
      rd_valid_b_q <= gnt[1];
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign bus.rd_valid_a = rd_valid_a_q;
  assign bus.rd_valid_b = rd_valid_b_q;
  assign written_count  = count_q;
  assign layer_done     = layer_done_q;

endmodule
